comma_sync_10b: RTL and testbench

Receive-side word aligner and link-synchronisation FSM for an 8b/10b serial link. It takes unaligned 10-bit parallel words from the deserializer and searches all ten bit offsets for the comma pattern. It locks onto an offset after repeated commas and delivers aligned 10-bit code groups, with a sync flag, to the downstream 8b/10b decoder. Loss of sync is driven by code-error feedback from that decoder.

---
 rtl/comma_sync_10b_if.sv | 24 ++
 rtl/comma_sync_10b.sv | 164 ++++++++++++++++
 tb/tb_comma_sync_10b.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/comma_sync_10b_if.sv
// Link bundle between the deserializer/decoder side and the 8b/10b word aligner.
// master: drives raw words and decoder error feedback, observes aligned output.
// slave : the aligner; consumes raw words, presents aligned code groups and sync status.
interface comma_sync_10b_if;
    logic       din_ena;
    logic [9:0] din_dat;
    logic       code_err;
    logic       dout_val;
    logic [9:0] dout_dat;
    logic       dout_comma;
    logic       sync;
    logic [3:0] align_ofs;
    logic       realign;

    modport master (
        output din_ena, din_dat, code_err,
        input  dout_val, dout_dat, dout_comma, sync, align_ofs, realign
    );

    modport slave (
        input  din_ena, din_dat, code_err,
        output dout_val, dout_dat, dout_comma, sync, align_ofs, realign
    );
endinterface

// File: rtl/comma_sync_10b.sv
// 8b/10b receive word aligner: searches all ten bit offsets for a comma, locks
// after ACQ_COMMAS same-offset commas, drops lock on decoder error feedback.
// Ports: clk, rst_n (async active-low), lnk (slave side of comma_sync_10b_if).
// One clock latency; every register advances only when din_ena is high.
module comma_sync_10b #(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_ERRS  = 4,
    parameter int ERR_DECAY  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    comma_sync_10b_if.slave  lnk
);

    typedef enum logic [1:0] {ST_LOS, ST_CDET, ST_SYNC} state_t;

    state_t     state;
    logic [9:0] prev;
    logic [3:0] cnt;
    logic [3:0] err_cnt;
    logic [7:0] good_cnt;
    logic [3:0] align_ofs_q;
    logic       dout_val_q;
    logic [9:0] dout_dat_q;
    logic       dout_comma_q;
    logic       sync_q;
    logic       realign_q;

    logic [19:0] window;
    logic [9:0]  comma_vec;
    logic        any_comma;
    logic [3:0]  first_k;
    logic        cur_comma;
    logic        take_new;
    logic [3:0]  new_ofs;
    logic [9:0]  new_dat;
    logic        new_comma;

    function automatic logic is_comma(input logic [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    // Candidate k is window[19-k -: 10]; a right shift by 10-k lands it in [9:0].
    function automatic logic [9:0] cand_at(input logic [19:0] w, input logic [3:0] k);
        logic [19:0] sh;
        sh = w >> (5'd10 - {1'b0, k});
        return sh[9:0];
    endfunction

    assign window = {prev, lnk.din_dat};

    always_comb begin
        comma_vec = '0;
        first_k   = '0;
        for (int k = 0; k < 10; k++) begin
            comma_vec[k] = is_comma(cand_at(window, 4'(k)));
        end
        // Scan downward so the lowest matching offset is the last one written.
        for (int k = 9; k >= 0; k--) begin
            if (comma_vec[k]) first_k = 4'(k);
        end
    end

    assign any_comma = |comma_vec;
    assign cur_comma = is_comma(cand_at(window, align_ofs_q));

    // The offset moves only out of LOS, or in CDET when a comma shows up
    // somewhere other than the current offset and no error overrides it.
    assign take_new  = (state == ST_LOS) ||
                       (state == ST_CDET && !lnk.code_err && !cur_comma);
    assign new_ofs   = (take_new && any_comma) ? first_k : align_ofs_q;
    assign new_dat   = cand_at(window, new_ofs);
    assign new_comma = is_comma(new_dat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOS;
            prev         <= '0;
            cnt          <= '0;
            err_cnt      <= '0;
            good_cnt     <= '0;
            align_ofs_q  <= '0;
            dout_val_q   <= 1'b0;
            dout_dat_q   <= '0;
            dout_comma_q <= 1'b0;
            sync_q       <= 1'b0;
            realign_q    <= 1'b0;
        end else if (!lnk.din_ena) begin
            dout_val_q <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            prev       <= lnk.din_dat;
            realign_q  <= 1'b0;
            dout_val_q <= 1'b0;

            // Output follows the post-edge offset so the comma that causes a
            // realign is itself delivered aligned.
            if (state != ST_LOS || any_comma) begin
                dout_val_q   <= 1'b1;
                dout_dat_q   <= new_dat;
                dout_comma_q <= new_comma;
            end

            case (state)
                ST_LOS: begin
                    if (any_comma) begin
                        align_ofs_q <= first_k;
                        cnt         <= 4'd1;
                        realign_q   <= (first_k != align_ofs_q);
                        state       <= ST_CDET;
                    end
                end
                ST_CDET: begin
                    if (lnk.code_err) begin
                        cnt   <= '0;
                        state <= ST_LOS;
                    end else if (cur_comma) begin
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == 4'(ACQ_COMMAS)) begin
                            err_cnt  <= '0;
                            good_cnt <= '0;
                            sync_q   <= 1'b1;
                            state    <= ST_SYNC;
                        end
                    end else if (any_comma) begin
                        align_ofs_q <= first_k;
                        cnt         <= 4'd1;
                        realign_q   <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (lnk.code_err) begin
                        good_cnt <= '0;
                        if (err_cnt + 4'd1 == 4'(LOSS_ERRS)) begin
                            err_cnt <= '0;
                            cnt     <= '0;
                            sync_q  <= 1'b0;
                            state   <= ST_LOS;
                        end else begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end else if (good_cnt + 8'd1 == 8'(ERR_DECAY)) begin
                        good_cnt <= '0;
                        if (err_cnt != 4'd0) err_cnt <= err_cnt - 4'd1;
                    end else begin
                        good_cnt <= good_cnt + 8'd1;
                    end
                end
                default: begin
                    sync_q <= 1'b0;
                    state  <= ST_LOS;
                end
            endcase
        end
    end

    assign lnk.dout_val   = dout_val_q;
    assign lnk.dout_dat   = dout_dat_q;
    assign lnk.dout_comma = dout_comma_q;
    assign lnk.sync       = sync_q;
    assign lnk.align_ofs  = align_ofs_q;
    assign lnk.realign    = realign_q;

endmodule

// File: tb/tb_comma_sync_10b.sv
// Bench for comma_sync_10b: a bit-stream generator feeds shifted K28.5 and junk,
// a bit-level reference model predicts every cycle's outputs into a queue, and a
// monitor pops and compares after each clock edge.
module tb_comma_sync_10b;

    localparam int ACQ   = 3;
    localparam int LOSS  = 4;
    localparam int DECAY = 4;
    localparam int M_LOS = 0, M_CDET = 1, M_SYNC = 2;

    typedef struct {
        logic       val;
        logic [9:0] dat;
        logic       comma;
        logic       sync;
        logic [3:0] ofs;
        logic       realign;
    } exp_t;

    logic clk;
    logic rst_n;
    comma_sync_10b_if lnk();

    comma_sync_10b #(.ACQ_COMMAS(ACQ), .LOSS_ERRS(LOSS), .ERR_DECAY(DECAY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lnk   (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   bq[$];
    bit   k_rd = 1'b0;

    // Reference model state
    int         m_state, m_cnt, m_err, m_good, m_ofs;
    logic [9:0] m_prev, m_dat;
    logic       m_comma, m_val, m_realign;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Received-order view: bits[0] is the earliest bit of the 20-bit window.
    function automatic logic [9:0] m_cand(input logic [9:0] p, input logic [9:0] d, input int k);
        bit bits[20];
        logic [9:0] c;
        for (int i = 0; i < 10; i++) begin
            bits[i]      = p[9-i];
            bits[10 + i] = d[9-i];
        end
        for (int i = 0; i < 10; i++) c[9-i] = bits[k + i];
        return c;
    endfunction

    function automatic bit m_is_comma(input logic [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    task automatic m_reset();
        m_state = M_LOS; m_cnt = 0; m_err = 0; m_good = 0; m_ofs = 0;
        m_prev = '0; m_dat = '0; m_comma = 0; m_val = 0; m_realign = 0;
    endtask

    task automatic m_step(input bit ena, input logic [9:0] din, input bit cerr);
        int first;
        bit cur;
        bit out;
        m_val = 0;
        m_realign = 0;
        if (ena) begin
            first = -1;
            for (int k = 9; k >= 0; k--)
                if (m_is_comma(m_cand(m_prev, din, k))) first = k;
            cur = m_is_comma(m_cand(m_prev, din, m_ofs));
            out = (m_state != M_LOS) || (first >= 0);
            if (m_state == M_LOS) begin
                if (first >= 0) begin
                    m_realign = (first != m_ofs);
                    m_ofs = first; m_cnt = 1; m_state = M_CDET;
                end
            end else if (m_state == M_CDET) begin
                if (cerr) begin
                    m_state = M_LOS; m_cnt = 0;
                end else if (cur) begin
                    m_cnt++;
                    if (m_cnt == ACQ) begin m_state = M_SYNC; m_err = 0; m_good = 0; end
                end else if (first >= 0) begin
                    m_ofs = first; m_cnt = 1; m_realign = 1;
                end
            end else begin
                if (cerr) begin
                    m_err++; m_good = 0;
                    if (m_err == LOSS) begin m_state = M_LOS; m_cnt = 0; m_err = 0; end
                end else begin
                    m_good++;
                    if (m_good == DECAY) begin
                        m_good = 0;
                        if (m_err > 0) m_err--;
                    end
                end
            end
            if (out) begin
                m_val   = 1;
                m_dat   = m_cand(m_prev, din, m_ofs);
                m_comma = m_is_comma(m_dat);
            end
            m_prev = din;
        end
    endtask

    // Drive one cycle at the falling edge and queue the prediction for the next rising edge.
    task automatic drive(input bit ena, input logic [9:0] din, input bit cerr);
        exp_t e;
        @(negedge clk);
        lnk.din_ena  = ena;
        lnk.din_dat  = din;
        lnk.code_err = cerr;
        m_step(ena, din, cerr);
        e.val = m_val; e.dat = m_dat; e.comma = m_comma;
        e.sync = (m_state == M_SYNC); e.ofs = 4'(m_ofs); e.realign = m_realign;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [9:0] din, input bit cerr);
        if ($urandom_range(0, 2) == 0)
            drive(1'b0, 10'($urandom), 1'($urandom));
        drive(1'b1, din, cerr);
    endtask

    task automatic push_k(input int n);
        logic [9:0] code;
        for (int j = 0; j < n; j++) begin
            code = k_rd ? 10'b1100000101 : 10'b0011111010;
            k_rd = ~k_rd;
            for (int i = 9; i >= 0; i--) bq.push_back(code[i]);
        end
    endtask

    task automatic push_bits(input int n, input bit zeros);
        for (int i = 0; i < n; i++) bq.push_back(zeros ? 1'b0 : 1'($urandom));
    endtask

    task automatic emit(input bit cerr);
        logic [9:0] w;
        for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
        send(w, cerr);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares whatever the DUT presents after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout_val",   32'(lnk.dout_val),   32'(e.val));
                chk("dout_dat",   32'(lnk.dout_dat),   32'(e.dat));
                chk("dout_comma", 32'(lnk.dout_comma), 32'(e.comma));
                chk("sync",       32'(lnk.sync),       32'(e.sync));
                chk("align_ofs",  32'(lnk.align_ofs),  32'(e.ofs));
                chk("realign",    32'(lnk.realign),    32'(e.realign));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        rst_n = 1'b0;
        lnk.din_ena = 1'b0; lnk.din_dat = '0; lnk.code_err = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sync", 32'(lnk.sync), 0);
        chk("reset_val",  32'(lnk.dout_val), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 10'($urandom), 1'b0);

        // Acquire at offset 3
        push_bits(3, 1'b0);
        push_k(8);
        for (int i = 0; i < 8; i++) emit(1'b0);
        settle();
        chk("acq_sync", 32'(lnk.sync), 1);
        chk("acq_ofs",  32'(lnk.align_ofs), 3);

        // Loss: four consecutive errors
        push_k(4);
        for (int i = 0; i < 4; i++) emit(1'b1);
        settle();
        chk("loss_sync", 32'(lnk.sync), 0);

        // Reacquire two commas at offset 3, then shift the stream to offset 7
        push_k(1);
        emit(1'b0);
        push_bits(4, 1'b1);
        push_k(6);
        emit(1'b0);
        emit(1'b0);
        settle();
        chk("realign_pulse", 32'(lnk.realign), 1);
        chk("realign_ofs",   32'(lnk.align_ofs), 7);
        chk("realign_nosync", 32'(lnk.sync), 0);
        for (int i = 0; i < 4; i++) emit(1'b0);
        settle();
        chk("resync_sync", 32'(lnk.sync), 1);
        chk("resync_ofs",  32'(lnk.align_ofs), 7);

        // Decay: errors on words 1..3, four good words, one error
        pat = 8'b11100001;
        push_k(12);
        for (int i = 0; i < 12; i++) emit(i < 8 ? pat[7-i] : 1'b0);
        settle();
        chk("decay_sync", 32'(lnk.sync), 1);

        // Asynchronous reset mid-SYNC
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_sync",  32'(lnk.sync), 0);
        chk("arst_val",   32'(lnk.dout_val), 0);
        chk("arst_dat",   32'(lnk.dout_dat), 0);
        chk("arst_comma", 32'(lnk.dout_comma), 0);
        chk("arst_ofs",   32'(lnk.align_ofs), 0);
        chk("arst_realign", 32'(lnk.realign), 0);
        m_reset();
        bq.delete();
        lnk.din_ena = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 10'($urandom), 1'($urandom));

        // Randomized segments of junk and shifted K28.5 with sparse errors
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                push_bits(10 * $urandom_range(1, 3), 1'b0);
                for (int i = 0; i < bq.size(); i++) bq[i] = 1'($urandom);
            end else begin
                push_bits($urandom_range(0, 9), 1'b0);
                push_k($urandom_range(4, 10));
            end
            while (bq.size() >= 10) emit($urandom_range(0, 15) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
